// File: rtl/down_timer_pkg.sv
// down_timer_pkg: shared types and defaults for the down_timer block.
//   state_e     : timer FSM state with fixed encodings (IDLE=00, RUN=01, DONE=10)
//   DefaultSize : default count width in bits
package down_timer_pkg;

  localparam int unsigned DefaultSize = 8;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/down_timer.sv
// down_timer: presettable down-counter/timer with terminal-count borrow pulse.
// Loads a preset, decrements once per non-inhibited clock in RUN, pulses borrowout on the
// 1 -> 0 step and either stops in DONE or reloads and keeps running (AUTORELOAD).
//
// Ports:
//   clock       in   rising-edge clock for all logic
//   reset       in   synchronous, active-low reset
//   clockinh    in   count inhibit; holds count and state while in RUN
//   load        in   capture loadvalue into count and reload register, go IDLE
//   loadvalue   in   preset value (SIZE bits)
//   start       in   begin counting from IDLE or DONE
//   countoutput out  current count (registered)
//   borrowout   out  one-cycle pulse on reaching terminal count (registered)
//   busy        out  high while in RUN (registered)
//   done        out  high while in DONE (registered)
module down_timer
  import down_timer_pkg::*;
#(
  parameter int unsigned SIZE       = DefaultSize,
  parameter bit          AUTORELOAD = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clockinh,
  input  logic            load,
  input  logic [SIZE-1:0] loadvalue,
  input  logic            start,
  output logic [SIZE-1:0] countoutput,
  output logic            borrowout,
  output logic            busy,
  output logic            done
);

  localparam logic [SIZE-1:0] One = {{(SIZE-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [SIZE-1:0] count_q, count_d;
  logic [SIZE-1:0] reload_q, reload_d;
  logic            borrow_q, borrow_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    borrow_d = 1'b0;

    if (load) begin
      // Load overrides everything below it, including a coincident start.
      count_d  = loadvalue;
      reload_d = loadvalue;
      state_d  = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            // A zero preset finishes immediately without a borrow.
            state_d = (count_q != '0) ? StRun : StDone;
          end
        end
        StRun: begin
          if (!clockinh) begin
            if (count_q <= One) begin
              // Terminal step; the <= also keeps an impossible zero count from wrapping.
              borrow_d = 1'b1;
              if (AUTORELOAD) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = StDone;
              end
            end else begin
              count_d = count_q - One;
            end
          end
        end
        StDone: begin
          count_d = '0;
          if (start && (reload_q != '0)) begin
            count_d = reload_q;
            state_d = StRun;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign countoutput = count_q;
  assign borrowout   = borrow_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: self-checking bench for down_timer. A one-shot instance is driven from a
// vector table; an auto-reload instance is driven by hand-written sequences. Each step pushes
// its expected outputs onto a scoreboard queue that is popped and compared after the edge.
module tb_down_timer;

  logic       clock = 1'b0;
  logic       reset;
  logic       clockinh;
  logic       load;
  logic [7:0] loadvalue;
  logic       start;

  logic [7:0] cnt0, cnt1;
  logic       brw0, brw1, busy0, busy1, done0, done1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int    rst_n, inh, ld, st, lv;
    int    cnt, brw, busy, done;
    string name;
  } vec_t;

  typedef struct {
    logic [10:0] exp;
    bit          sel;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  always #5 clock = ~clock;

  down_timer #(.SIZE(8), .AUTORELOAD(1'b0)) u_dut_oneshot (
    .clock      (clock),
    .reset      (reset),
    .clockinh   (clockinh),
    .load       (load),
    .loadvalue  (loadvalue),
    .start      (start),
    .countoutput(cnt0),
    .borrowout  (brw0),
    .busy       (busy0),
    .done       (done0)
  );

  down_timer #(.SIZE(8), .AUTORELOAD(1'b1)) u_dut_reload (
    .clock      (clock),
    .reset      (reset),
    .clockinh   (clockinh),
    .load       (load),
    .loadvalue  (loadvalue),
    .start      (start),
    .countoutput(cnt1),
    .borrowout  (brw1),
    .busy       (busy1),
    .done       (done1)
  );

  task automatic v(input int rst_n, inh, ld, st, lv, cnt, brw, busy, done, input string name);
    vec_t r;
    r.rst_n = rst_n; r.inh = inh; r.ld = ld; r.st = st; r.lv = lv;
    r.cnt = cnt; r.brw = brw; r.busy = busy; r.done = done; r.name = name;
    vecs.push_back(r);
  endtask

  task automatic check_out();
    exp_t        e;
    logic [10:0] got;
    e = sb_q.pop_front();
    got = e.sel ? {cnt1, brw1, busy1, done1} : {cnt0, brw0, busy0, done0};
    n_tests++;
    if (got !== e.exp) begin
      n_fail++;
      $display("FAIL %s (t=%0t): got cnt=%0d brw=%b busy=%b done=%b, expected cnt=%0d brw=%b busy=%b done=%b",
               e.name, $time, got[10:3], got[2], got[1], got[0],
               e.exp[10:3], e.exp[2], e.exp[1], e.exp[0]);
    end
  endtask

  // Drive one edge's inputs, queue the expected post-edge outputs, then check after the edge.
  task automatic step(input int rst_n, inh, ld, st, lv, input bit sel,
                      input int cnt, brw, busy, done, input string name);
    exp_t e;
    reset     = rst_n[0];
    clockinh  = inh[0];
    load      = ld[0];
    start     = st[0];
    loadvalue = lv[7:0];
    e.exp  = {cnt[7:0], brw[0], busy[0], done[0]};
    e.sel  = sel;
    e.name = name;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    check_out();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; clockinh = 1'b0; load = 1'b0; start = 1'b0; loadvalue = '0;

    //  rst inh ld st lv   cnt brw busy done
    // Basic one-shot run from 5.
    v(0, 0, 0, 0, 0,   0, 0, 0, 0, "reset_state");
    v(1, 0, 1, 0, 5,   5, 0, 0, 0, "load5");
    v(1, 0, 0, 1, 0,   5, 0, 1, 0, "start5");
    v(1, 0, 0, 0, 0,   4, 0, 1, 0, "dec4");
    v(1, 0, 0, 0, 0,   3, 0, 1, 0, "dec3");
    v(1, 0, 0, 0, 0,   2, 0, 1, 0, "dec2");
    v(1, 0, 0, 0, 0,   1, 0, 1, 0, "dec1");
    v(1, 0, 0, 0, 0,   0, 1, 0, 1, "terminal_borrow");
    v(1, 0, 0, 0, 0,   0, 0, 0, 1, "borrow_drops");
    v(1, 0, 0, 0, 0,   0, 0, 0, 1, "done_held");
    // Inhibit stretches the run by two cycles.
    v(1, 0, 1, 0, 4,   4, 0, 0, 0, "load4");
    v(1, 0, 0, 1, 0,   4, 0, 1, 0, "start4");
    v(1, 0, 0, 0, 0,   3, 0, 1, 0, "inh_dec3");
    v(1, 1, 0, 0, 0,   3, 0, 1, 0, "inh_hold_a");
    v(1, 1, 0, 0, 0,   3, 0, 1, 0, "inh_hold_b");
    v(1, 0, 0, 0, 0,   2, 0, 1, 0, "inh_dec2");
    v(1, 0, 0, 0, 0,   1, 0, 1, 0, "inh_dec1");
    v(1, 0, 0, 0, 0,   0, 1, 0, 1, "inh_borrow_at_6");
    v(1, 0, 0, 0, 0,   0, 0, 0, 1, "inh_done");
    // Zero preset goes straight to DONE with no borrow.
    v(1, 0, 1, 0, 0,   0, 0, 0, 0, "load0");
    v(1, 0, 0, 1, 0,   0, 0, 0, 1, "start0_done");
    v(1, 0, 0, 0, 0,   0, 0, 0, 1, "zero_no_borrow");
    v(1, 0, 1, 0, 7,   7, 0, 0, 0, "load7_from_done");
    v(1, 0, 0, 1, 0,   7, 0, 1, 0, "start7");
    v(1, 0, 0, 0, 0,   6, 0, 1, 0, "run7_dec6");
    // Reset mid-run aborts silently.
    v(1, 0, 1, 0, 8,   8, 0, 0, 0, "load8");
    v(1, 0, 0, 1, 0,   8, 0, 1, 0, "start8");
    v(1, 0, 0, 0, 0,   7, 0, 1, 0, "r8_dec7");
    v(1, 0, 0, 0, 0,   6, 0, 1, 0, "r8_dec6");
    v(1, 0, 0, 0, 0,   5, 0, 1, 0, "r8_dec5");
    v(1, 0, 0, 0, 0,   4, 0, 1, 0, "r8_dec4");
    v(1, 0, 0, 0, 0,   3, 0, 1, 0, "r8_dec3");
    v(0, 0, 0, 0, 0,   0, 0, 0, 0, "reset_midrun");
    v(1, 0, 0, 0, 0,   0, 0, 0, 0, "after_reset_no_borrow");
    // Load and start together: load wins.
    v(1, 0, 1, 1, 9,   9, 0, 0, 0, "load_start_same_edge");
    v(1, 0, 0, 0, 0,   9, 0, 0, 0, "start_dropped_idle");
    // Re-run from the reload register in DONE; start in RUN ignored.
    v(1, 0, 1, 0, 2,   2, 0, 0, 0, "load2");
    v(1, 0, 0, 1, 0,   2, 0, 1, 0, "start2");
    v(1, 0, 0, 0, 0,   1, 0, 1, 0, "r2_dec1");
    v(1, 0, 0, 0, 0,   0, 1, 0, 1, "r2_borrow1");
    v(1, 0, 0, 0, 0,   0, 0, 0, 1, "r2_done");
    v(1, 0, 0, 1, 0,   2, 0, 1, 0, "rerun_from_done");
    v(1, 0, 0, 1, 0,   1, 0, 1, 0, "start_in_run_ignored");
    v(1, 0, 0, 0, 0,   0, 1, 0, 1, "r2_borrow2");
    v(1, 0, 0, 0, 0,   0, 0, 0, 1, "r2_done2");
    // DONE with zero reload stays DONE.
    v(1, 0, 1, 0, 0,   0, 0, 0, 0, "load0_again");
    v(1, 0, 0, 1, 0,   0, 0, 0, 1, "start0_again");
    v(1, 0, 0, 1, 0,   0, 0, 0, 1, "done_reload0_stays");
    // Load aborts a run.
    v(1, 0, 1, 0, 3,   3, 0, 0, 0, "load3");
    v(1, 0, 0, 1, 0,   3, 0, 1, 0, "start3");
    v(1, 0, 0, 0, 0,   2, 0, 1, 0, "r3_dec2");
    v(1, 0, 1, 0, 6,   6, 0, 0, 0, "load_aborts_run");
    v(1, 0, 0, 0, 0,   6, 0, 0, 0, "idle_after_abort");

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].inh, vecs[i].ld, vecs[i].st, vecs[i].lv, 1'b0,
           vecs[i].cnt, vecs[i].brw, vecs[i].busy, vecs[i].done, vecs[i].name);
    end

    // Auto-reload, period 3: counts 3,2,1,3,2,1,... with a borrow on each reload.
    step(0, 0, 0, 0, 0, 1'b1, 0, 0, 0, 0, "ar_reset");
    step(1, 0, 1, 0, 3, 1'b1, 3, 0, 0, 0, "ar_load3");
    step(1, 0, 0, 1, 0, 1'b1, 3, 0, 1, 0, "ar_start3");
    for (int i = 1; i <= 10; i++) begin
      if (i % 3 == 0) step(1, 0, 0, 0, 0, 1'b1, 3, 1, 1, 0, "ar_reload_borrow");
      else            step(1, 0, 0, 0, 0, 1'b1, 3 - (i % 3), 0, 1, 0, "ar_count");
    end
    // Inhibit in auto-reload holds the count.
    step(1, 1, 0, 0, 0, 1'b1, 2, 0, 1, 0, "ar_inh_hold");
    step(1, 0, 0, 0, 0, 1'b1, 1, 0, 1, 0, "ar_after_inh");
    step(1, 0, 0, 0, 0, 1'b1, 3, 1, 1, 0, "ar_reload_after_inh");

    // Auto-reload with value 1 borrows every non-inhibited cycle.
    step(1, 0, 1, 0, 1, 1'b1, 1, 0, 0, 0, "ar_load1");
    step(1, 0, 0, 1, 0, 1'b1, 1, 0, 1, 0, "ar_start1");
    step(1, 0, 0, 0, 0, 1'b1, 1, 1, 1, 0, "ar1_borrow_a");
    step(1, 0, 0, 0, 0, 1'b1, 1, 1, 1, 0, "ar1_borrow_b");
    step(1, 1, 0, 0, 0, 1'b1, 1, 0, 1, 0, "ar1_inh_no_borrow");
    step(1, 0, 0, 0, 0, 1'b1, 1, 1, 1, 0, "ar1_borrow_c");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
